// File: rtl/databus_ctrl.sv
// databus_ctrl: master for the shared 12-bit tri-state data bus.
// Requests {src,dst,data} are queued in a small FIFO and executed one at a
// time as DRIVE -> STROBE -> HOLD -> TURN. This sequence guarantees settle
// time before the capture strobe, hold time after it, and a dead cycle
// between different bus drivers.
module databus_ctrl #(
    parameter int NODES  = 4,
    parameter int SETTLE = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_src,
    input  logic [2:0]        req_dst,
    input  logic [11:0]       req_data,
    output logic [NODES-1:0]  link_bus,
    output logic [NODES-1:0]  write,
    inout  wire  [11:0]       Data_bus,
    output logic              done,
    output logic [11:0]       done_data,
    output logic              err,
    output logic              busy
);

    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] CTRL_SRC    = 3'd7;
    localparam logic [3:0] NODES_W     = 4'(NODES);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        STROBE,
        HOLD,
        TURN
    } state_t;

    // FIFO storage: {src[2:0], dst[2:0], data[11:0]}
    logic [17:0]    fifo_mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           fifo_empty;
    logic           fifo_full;
    logic           req_legal;
    logic           push;

    logic [17:0]    head_entry;
    logic [2:0]     head_src;
    logic [2:0]     head_dst;
    logic [11:0]    head_data;
    logic [NODES-1:0] head_src_oh;
    logic [NODES-1:0] head_dst_oh;

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic [NODES-1:0] link_reg;
    logic [NODES-1:0] write_reg;
    logic [NODES-1:0] dst_oh_reg;
    logic             drive_en_reg;
    logic [11:0]      drive_data_reg;
    logic             done_reg;
    logic [11:0]      done_data_reg;
    logic             err_reg;

    // Full/empty come only from registered pointers, so a pop in the same
    // cycle never frees a slot for a push.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign req_ready  = !fifo_full;

    // The source must be a real node or the controller itself. The
    // destination must be a real node that differs from the source.
    assign req_legal = ({1'b0, req_dst} < NODES_W) &&
                       (({1'b0, req_src} < NODES_W) || (req_src == CTRL_SRC)) &&
                       (req_src != req_dst);
    assign push = req_valid && req_ready && req_legal;

    // The head is read combinationally so that the enables can be loaded
    // into output registers on the same edge that pops it.
    assign head_entry = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign head_src   = head_entry[17:15];
    assign head_dst   = head_entry[14:12];
    assign head_data  = head_entry[11:0];

    genvar gi;
    generate
        for (gi = 0; gi < NODES; gi++) begin : g_dec
            assign head_src_oh[gi] = (head_src == 3'(gi));
            assign head_dst_oh[gi] = (head_dst == 3'(gi));
        end
    endgenerate

    // FIFO storage write; the contents need no reset because the pointers
    // define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {req_src, req_dst, req_data};
        end
    end

    // Write pointer and the rejection pulse for illegal requests that were
    // consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            err_reg <= req_valid && req_ready && !req_legal;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // Transfer sequencer: it pops the head, drives the source, strobes the
    // destination, holds, then releases the bus for one turnaround cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            rd_ptr_reg     <= '0;
            cnt_reg        <= '0;
            link_reg       <= '0;
            write_reg      <= '0;
            dst_oh_reg     <= '0;
            drive_en_reg   <= 1'b0;
            drive_data_reg <= '0;
            done_reg       <= 1'b0;
            done_data_reg  <= '0;
        end else begin
            done_reg  <= 1'b0;
            write_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        rd_ptr_reg     <= rd_ptr_reg + (AW+1)'(1);
                        cnt_reg        <= '0;
                        dst_oh_reg     <= head_dst_oh;
                        drive_data_reg <= head_data;
                        if (head_src == CTRL_SRC) begin
                            drive_en_reg <= 1'b1;
                            link_reg     <= '0;
                        end else begin
                            drive_en_reg <= 1'b0;
                            link_reg     <= head_src_oh;
                        end
                        state_reg <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == SETTLE_LAST) begin
                        write_reg <= dst_oh_reg;
                        state_reg <= STROBE;
                    end
                end
                STROBE: begin
                    done_data_reg <= Data_bus;
                    done_reg      <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    link_reg     <= '0;
                    drive_en_reg <= 1'b0;
                    state_reg    <= TURN;
                end
                TURN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    link_reg     <= '0;
                    drive_en_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign Data_bus  = drive_en_reg ? drive_data_reg : 12'hzzz;
    assign link_bus  = link_reg;
    assign write     = write_reg;
    assign done      = done_reg;
    assign done_data = done_data_reg;
    assign err       = err_reg;
    assign busy      = !fifo_empty || (state_reg != IDLE);

endmodule
